// File: rtl/wrr_quantum_arbiter.sv
// Weighted round-robin arbiter: grants one requester at a time and holds the grant while
// the request stays high, up to that requester's weight in cycles, then preempts.
module wrr_quantum_arbiter #(
  parameter int WIDTH    = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = 2
) (
  input  logic                      in_clk,
  input  logic                      in_reset,
  input  logic                      in_enable,
  input  logic [WIDTH-1:0]          in_request,
  input  logic [WIDTH*WEIGHT_W-1:0] in_weight,
  output logic [WIDTH-1:0]          out_grant,
  output logic                      out_grant_valid,
  output logic [ID_W-1:0]           out_grant_id,
  output logic                      out_preempt,
  output logic [1:0]                out_dbg_state,
  output logic [WIDTH-1:0]          out_dbg_base
);

  // Handshake: a requester owns the bus on every cycle out_grant[i] is high; dropping
  // in_request[i] releases it, and out_preempt marks the cycle after a forced removal.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WEIGHT_W-1:0]  count_q, count_d;
  logic [WEIGHT_W-1:0]  wlat_q, wlat_d;
  logic [WIDTH-1:0]     grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 preempt_q, preempt_d;

  logic [WIDTH-1:0]     eligible;
  logic [ID_W-1:0]      base_idx;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_found;
  logic [WEIGHT_W-1:0]  pick_weight;
  logic [WIDTH-1:0]     grant_rotl;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < WIDTH; i++) begin
      eligible[i] = in_request[i] && (in_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  always_comb begin
    base_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (base_q[i]) base_idx = ID_W'(i);
    end
  end

  // Two passes give the wrap-around scan: first at/above base, then from bit 0.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!pick_found && eligible[i] && (ID_W'(i) >= base_idx)) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!pick_found && eligible[i]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(i);
      end
    end
  end

  assign pick_weight = in_weight[pick_idx*WEIGHT_W +: WEIGHT_W];
  assign grant_rotl  = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    wlat_d    = wlat_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    id_d      = id_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        valid_d = 1'b0;
        id_d    = '0;
        if (in_enable && (eligible != '0)) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (in_enable && pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          valid_d           = 1'b1;
          id_d              = pick_idx;
          wlat_d            = pick_weight;
          count_d           = WEIGHT_W'(1);
          state_d           = ST_HOLD;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
          id_d    = '0;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Release wins over expiry, so out_preempt only fires while the request is still up.
        if (!in_request[id_q] || (count_q == wlat_q)) begin
          preempt_d = in_request[id_q];
          grant_d   = '0;
          valid_d   = 1'b0;
          id_d      = '0;
          base_d    = grant_rotl;
          state_d   = (in_enable && (eligible != '0)) ? ST_GRANT : ST_IDLE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        id_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q   <= ST_IDLE;
      base_q    <= WIDTH'(1);
      count_q   <= '0;
      wlat_q    <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      wlat_q    <= wlat_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      preempt_q <= preempt_d;
    end
  end

  assign out_grant       = grant_q;
  assign out_grant_valid = valid_q;
  assign out_grant_id    = id_q;
  assign out_preempt     = preempt_q;
  assign out_dbg_state   = state_q;
  assign out_dbg_base    = base_q;

endmodule

// File: tb/tb_wrr_quantum_arbiter.sv
// Bench for wrr_quantum_arbiter: directed scenarios plus random traffic, checked every
// cycle against an owner/pointer model of the arbitration rules.
module tb_wrr_quantum_arbiter;

  localparam int W  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            in_clk = 1'b0;
  logic            in_reset;
  logic            in_enable;
  logic [W-1:0]    in_request;
  logic [W*WW-1:0] in_weight;
  logic [W-1:0]    out_grant;
  logic            out_grant_valid;
  logic [IW-1:0]   out_grant_id;
  logic            out_preempt;
  logic [1:0]      out_dbg_state;
  logic [W-1:0]    out_dbg_base;

  wrr_quantum_arbiter #(.WIDTH(W), .WEIGHT_W(WW), .ID_W(IW)) dut (
    .in_clk          (in_clk),
    .in_reset        (in_reset),
    .in_enable       (in_enable),
    .in_request      (in_request),
    .in_weight       (in_weight),
    .out_grant       (out_grant),
    .out_grant_valid (out_grant_valid),
    .out_grant_id    (out_grant_id),
    .out_preempt     (out_preempt),
    .out_dbg_state   (out_dbg_state),
    .out_dbg_base    (out_dbg_base)
  );

  // clock / reset
  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  // {state, base, preempt, id, valid, grant}
  logic [13:0] exp_q[$];

  // Reference model: who owns the bus, for how long, and where the round-robin pointer is.
  int holder   = -1;
  int held     = 0;
  int quantum  = 0;
  int ptr      = 0;
  bit arb_next = 1'b0;
  bit m_pre    = 1'b0;

  function automatic logic [W-1:0] elig_of(input logic [W-1:0] r, input logic [W*WW-1:0] w);
    logic [W-1:0] e;
    for (int i = 0; i < W; i++) e[i] = r[i] && (w[i*WW +: WW] != 0);
    return e;
  endfunction

  always @(posedge in_clk) begin : model
    logic [W-1:0] el;
    logic [13:0]  e;
    logic [1:0]   st;
    logic [W-1:0] g;
    el = elig_of(in_request, in_weight);
    m_pre = 1'b0;
    if (in_reset) begin
      holder = -1; ptr = 0; arb_next = 1'b0;
    end else if (holder >= 0) begin
      if (!in_request[holder] || held == quantum) begin
        m_pre    = in_request[holder];
        ptr      = (holder + 1) % W;
        holder   = -1;
        arb_next = in_enable && (el != 0);
      end else begin
        held++;
      end
    end else if (arb_next) begin
      arb_next = 1'b0;
      if (in_enable && (el != 0)) begin
        for (int k = 0; k < W; k++) begin
          if (holder < 0 && el[(ptr + k) % W]) holder = (ptr + k) % W;
        end
        quantum = int'(in_weight[holder*WW +: WW]);
        held    = 1;
      end
    end else begin
      arb_next = in_enable && (el != 0);
    end
    st = (holder >= 0) ? 2'd2 : (arb_next ? 2'd1 : 2'd0);
    g  = (holder >= 0) ? W'(1 << holder) : '0;
    e  = {st, W'(1 << ptr), m_pre, (holder >= 0) ? IW'(holder) : IW'(0), (holder >= 0), g};
    exp_q.push_back(e);
  end

  // monitor / scoreboard
  always @(negedge in_clk) begin
    logic [13:0] act;
    logic [13:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {out_dbg_state, out_dbg_base, out_preempt, out_grant_id, out_grant_valid, out_grant};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got st=%0d base=%b pre=%b id=%0d v=%b g=%b required st=%0d base=%b pre=%b id=%0d v=%b g=%b",
                 $time, act[13:12], act[11:8], act[7], act[6:5], act[4], act[3:0],
                 exp[13:12], exp[11:8], exp[7], exp[6:5], exp[4], exp[3:0]);
      end
    end
  end

  // driver
  task automatic drive(input logic [W-1:0] r, input logic [W*WW-1:0] w,
                       input bit en, input bit rst, input int n);
    in_request = r;
    in_weight  = w;
    in_enable  = en;
    in_reset   = rst;
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (out_grant !== '0 || out_grant_valid !== 1'b0 || out_grant_id !== '0 ||
        out_preempt !== 1'b0 || out_dbg_state !== 2'd0 || out_dbg_base !== 4'b0001) begin
      errors++;
      $display("FAIL reset_state %s t=%0t got st=%0d base=%b pre=%b id=%0d v=%b g=%b required st=0 base=0001 pre=0 id=0 v=0 g=0000",
               tag, $time, out_dbg_state, out_dbg_base, out_preempt, out_grant_id,
               out_grant_valid, out_grant);
    end
  endtask

  task automatic wait_for_grant(input logic [W-1:0] g, input int max_cycles);
    int n;
    n = 0;
    while (out_grant !== g && n < max_cycles) begin
      @(posedge in_clk);
      #1;
      n++;
    end
    checks++;
    if (out_grant !== g) begin
      errors++;
      $display("FAIL wait_expired t=%0t grant=%b not seen within %0d cycles, got %b",
               $time, g, max_cycles, out_grant);
    end
  endtask

  initial begin
    logic [W*WW-1:0] w;
    // reset with all requests high
    drive(4'b1111, 16'h3333, 1'b1, 1'b1, 2);
    check_reset_state("initial");
    // single requester, repeated quantum expiry
    drive(4'b0100, 16'h3333, 1'b1, 1'b0, 2);
    wait_for_grant(4'b0100, 2);
    drive(4'b0100, 16'h3333, 1'b1, 1'b0, 10);
    // rotation across all four
    drive(4'b0000, 16'h2222, 1'b1, 1'b1, 1);
    drive(4'b1111, 16'h2222, 1'b1, 1'b0, 16);
    // early release and masked requester 3
    drive(4'b0000, 16'h0515, 1'b1, 1'b1, 1);
    drive(4'b1001, 16'h0515, 1'b1, 1'b0, 4);
    drive(4'b1000, 16'h0515, 1'b1, 1'b0, 6);
    // weight change mid-hold, then enable low mid-hold
    drive(4'b0010, 16'h4444, 1'b1, 1'b0, 4);
    drive(4'b0010, 16'hffff, 1'b1, 1'b0, 8);
    drive(4'b0010, 16'h3333, 1'b0, 1'b0, 12);
    drive(4'b0010, 16'h3333, 1'b1, 1'b0, 6);
    // reset in the middle of a hold
    drive(4'b0010, 16'h5555, 1'b1, 1'b0, 4);
    drive(4'b1111, 16'h5555, 1'b1, 1'b1, 1);
    check_reset_state("mid_hold");
    drive(4'b1111, 16'h5555, 1'b1, 1'b0, 10);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < W; j++) begin
        w[j*WW +: WW] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      end
      drive(4'($urandom_range(0, 15)), w, $urandom_range(0, 9) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(1, 6));
    end
    drive(4'b0000, 16'h0000, 1'b1, 1'b0, 3);
    @(negedge in_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
